// File: rtl/qtable_pkg.sv
// Shared constants for the JPEG quantisation-table manager: scan geometry,
// the standard zigzag order and the divide-by-1 default entry.
package qtable_pkg;

   localparam int QT_ENTRIES = 64;
   localparam int QT_IDX_W   = 6;
   localparam int QT_DEFAULT = 1;

   // Zigzag position k -> raster index
   localparam logic [QT_IDX_W-1:0] ZIGZAG [QT_ENTRIES] = '{
      6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
      6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
      6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
      6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
      6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
      6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
      6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
      6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
   };

   function automatic logic [QT_IDX_W-1:0] scan_map(input logic [QT_IDX_W-1:0] k,
                                                    input logic                zz);
      return zz ? ZIGZAG[k] : k;
   endfunction

endpackage

// File: rtl/qtable_scan.sv
// One read client: scan counter, latched table/order, index mapping and the
// registered data/valid/last stage fed by the shared table storage.
module qtable_scan
   import qtable_pkg::*;
#(
   parameter int NUM_TBL = 2,
   parameter int DATA_W  = 8,
   parameter int TBL_W   = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [TBL_W-1:0]    tbl,
   input  logic                zz,
   input  logic                rd,
   input  logic [DATA_W-1:0]   rd_word,
   output logic [TBL_W-1:0]    rd_tbl,
   output logic [QT_IDX_W-1:0] rd_idx,
   output logic                start_err,
   output logic                active,
   output logic [DATA_W-1:0]   data,
   output logic                vld,
   output logic                last
);

   logic [QT_IDX_W-1:0] cnt;
   logic [QT_IDX_W-1:0] cnt_eff;
   logic [TBL_W-1:0]    tbl_lat;
   logic                zz_lat;
   logic                zz_eff;
   logic [DATA_W-1:0]   data_p1;
   logic                vld_p1;
   logic                last_p1;

   // A start in the same cycle as rd takes effect for that read
   always_comb begin
      start_err = start && (int'(tbl) >= NUM_TBL);
      rd_tbl    = tbl_lat;
      zz_eff    = zz_lat;
      cnt_eff   = cnt;
      if (start) begin
         rd_tbl  = start_err ? '0 : tbl;
         zz_eff  = zz;
         cnt_eff = '0;
      end
      rd_idx = scan_map(cnt_eff, zz_eff);
   end

   // Stage p1: registered read data and strobes
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt     <= '0;
         tbl_lat <= '0;
         zz_lat  <= 1'b1;
         data_p1 <= '0;
         vld_p1  <= 1'b0;
         last_p1 <= 1'b0;
      end else begin
         if (start) begin
            tbl_lat <= rd_tbl;
            zz_lat  <= zz;
         end
         if (rd)
            cnt <= cnt_eff + 1'b1;
         else if (start)
            cnt <= '0;
         vld_p1  <= rd;
         last_p1 <= rd && (cnt_eff == QT_IDX_W'(QT_ENTRIES - 1));
         if (rd)
            data_p1 <= rd_word;
      end
   end

   assign active = |cnt;
   assign data   = data_p1;
   assign vld    = vld_p1;
   assign last   = last_p1;

endmodule

// File: rtl/qtable_ctrl.sv
// Quantisation-table manager: NUM_TBL host-loaded 64-entry tables served to
// the DQT packer (zigzag) and the quantizer (zigzag or raster).
module qtable_ctrl
   import qtable_pkg::*;
#(
   parameter  int NUM_TBL = 2,
   parameter  int DATA_W  = 8,
   localparam int TBL_W   = (NUM_TBL > 1) ? $clog2(NUM_TBL) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                wr_en,
   input  logic [TBL_W-1:0]    wr_tbl,
   input  logic [QT_IDX_W-1:0] wr_idx,
   input  logic [DATA_W-1:0]   wr_data,
   input  logic                pack_start,
   input  logic [TBL_W-1:0]    pack_tbl,
   input  logic                pack_rd,
   output logic [DATA_W-1:0]   pack_data,
   output logic                pack_vld,
   output logic                pack_last,
   input  logic                qnt_start,
   input  logic [TBL_W-1:0]    qnt_tbl,
   input  logic                qnt_zz,
   input  logic                qnt_rd,
   output logic [DATA_W-1:0]   qnt_data,
   output logic                qnt_vld,
   output logic                qnt_last,
   output logic                busy,
   output logic                tbl_err
);

   logic [DATA_W-1:0]   mem [NUM_TBL][QT_ENTRIES];
   logic                wr_ok;
   logic [TBL_W-1:0]    pack_rtbl, qnt_rtbl;
   logic [QT_IDX_W-1:0] pack_ridx, qnt_ridx;
   logic [DATA_W-1:0]   pack_word, qnt_word;
   logic                pack_serr, qnt_serr;
   logic                pack_act, qnt_act;

   assign wr_ok = int'(wr_tbl) < NUM_TBL;

   // Reads see the pre-edge contents, so a same-cycle write returns the old value
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int t = 0; t < NUM_TBL; t++)
            for (int i = 0; i < QT_ENTRIES; i++)
               mem[t][i] <= DATA_W'(QT_DEFAULT);
      end else if (wr_en && wr_ok) begin
         mem[wr_tbl][wr_idx] <= wr_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         tbl_err <= 1'b0;
      else if ((wr_en && !wr_ok) || pack_serr || qnt_serr)
         tbl_err <= 1'b1;
   end

   assign pack_word = mem[pack_rtbl][pack_ridx];
   assign qnt_word  = mem[qnt_rtbl][qnt_ridx];

   qtable_scan #(.NUM_TBL(NUM_TBL), .DATA_W(DATA_W), .TBL_W(TBL_W)) u_pack (
      .clk       (clk),
      .rst       (rst),
      .start     (pack_start),
      .tbl       (pack_tbl),
      .zz        (1'b1),
      .rd        (pack_rd),
      .rd_word   (pack_word),
      .rd_tbl    (pack_rtbl),
      .rd_idx    (pack_ridx),
      .start_err (pack_serr),
      .active    (pack_act),
      .data      (pack_data),
      .vld       (pack_vld),
      .last      (pack_last)
   );

   qtable_scan #(.NUM_TBL(NUM_TBL), .DATA_W(DATA_W), .TBL_W(TBL_W)) u_qnt (
      .clk       (clk),
      .rst       (rst),
      .start     (qnt_start),
      .tbl       (qnt_tbl),
      .zz        (qnt_zz),
      .rd        (qnt_rd),
      .rd_word   (qnt_word),
      .rd_tbl    (qnt_rtbl),
      .rd_idx    (qnt_ridx),
      .start_err (qnt_serr),
      .active    (qnt_act),
      .data      (qnt_data),
      .vld       (qnt_vld),
      .last      (qnt_last)
   );

   assign busy = pack_act | qnt_act;

endmodule

// File: tb/tb_qtable_ctrl.sv
// Directed bench for qtable_ctrl with three tables so that an out-of-range
// table select (3) is representable on the 2-bit select ports.
module tb_qtable_ctrl;

   localparam int NT = 3;
   localparam int DW = 8;
   localparam int TW = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          wr_en;
   logic [TW-1:0] wr_tbl;
   logic [5:0]    wr_idx;
   logic [DW-1:0] wr_data;
   logic          pack_start, pack_rd, pack_vld, pack_last;
   logic [TW-1:0] pack_tbl;
   logic [DW-1:0] pack_data;
   logic          qnt_start, qnt_zz, qnt_rd, qnt_vld, qnt_last;
   logic [TW-1:0] qnt_tbl;
   logic [DW-1:0] qnt_data;
   logic          busy, tbl_err;

   int total = 0;
   int bad   = 0;

   logic [DW-1:0] mem_m [NT][64];
   logic [5:0] zzt [64] = '{
      6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
      6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
      6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
      6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
      6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
      6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
      6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
      6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
   };

   always #5 clk = ~clk;

   qtable_ctrl #(.NUM_TBL(NT), .DATA_W(DW)) dut (
      .clk        (clk),
      .rst        (rst),
      .wr_en      (wr_en),
      .wr_tbl     (wr_tbl),
      .wr_idx     (wr_idx),
      .wr_data    (wr_data),
      .pack_start (pack_start),
      .pack_tbl   (pack_tbl),
      .pack_rd    (pack_rd),
      .pack_data  (pack_data),
      .pack_vld   (pack_vld),
      .pack_last  (pack_last),
      .qnt_start  (qnt_start),
      .qnt_tbl    (qnt_tbl),
      .qnt_zz     (qnt_zz),
      .qnt_rd     (qnt_rd),
      .qnt_data   (qnt_data),
      .qnt_vld    (qnt_vld),
      .qnt_last   (qnt_last),
      .busy       (busy),
      .tbl_err    (tbl_err)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int t = 0; t < NT; t++)
         for (int i = 0; i < 64; i++)
            mem_m[t][i] = 8'd1;
   endtask

   // Start a quantizer scan then read all 64 entries back-to-back
   task automatic qnt_scan(input int tbl, input logic zzv);
      qnt_start = 1'b1; qnt_tbl = TW'(tbl); qnt_zz = zzv;
      step();
      qnt_start = 1'b0;
      for (int k = 0; k < 64; k++) begin
         qnt_rd = 1'b1;
         step();
         chk("qnt_vld", qnt_vld, 1);
         chk("qnt_data", qnt_data, mem_m[tbl][zzv ? int'(zzt[k]) : k]);
         chk("qnt_last", qnt_last, (k == 63));
      end
      qnt_rd = 1'b0;
      step();
      chk("qnt_vld_idle", qnt_vld, 0);
   endtask

   initial begin
      int kp, kq, guard;
      logic rp, rq;
      rst = 1'b1;
      wr_en = 0; wr_tbl = 0; wr_idx = 0; wr_data = 0;
      pack_start = 0; pack_tbl = 0; pack_rd = 0;
      qnt_start = 0; qnt_tbl = 0; qnt_zz = 0; qnt_rd = 0;
      model_reset();
      step();
      step();
      chk("rst_pack_data", pack_data, 0);
      chk("rst_pack_vld", pack_vld, 0);
      chk("rst_qnt_data", qnt_data, 0);
      chk("rst_qnt_last", qnt_last, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", tbl_err, 0);
      rst = 1'b0;
      step();

      // Default tables: every entry reads back as 1
      pack_start = 1'b1; pack_tbl = 0;
      step();
      pack_start = 1'b0;
      chk("busy_after_start", busy, 0);
      for (int k = 0; k < 64; k++) begin
         pack_rd = 1'b1;
         step();
         chk("def_vld", pack_vld, 1);
         chk("def_data", pack_data, 1);
         chk("def_last", pack_last, (k == 63));
         if (k == 10) chk("def_busy_mid", busy, 1);
      end
      pack_rd = 1'b0;
      step();
      chk("def_vld_idle", pack_vld, 0);
      chk("def_busy_end", busy, 0);

      // Load tbl0 = i, tbl1 = 100+i
      for (int t = 0; t < 2; t++)
         for (int i = 0; i < 64; i++) begin
            wr_en = 1'b1; wr_tbl = TW'(t); wr_idx = 6'(i);
            wr_data = DW'(t * 100 + i);
            step();
            mem_m[t][i] = DW'(t * 100 + i);
         end
      wr_en = 1'b0;

      qnt_scan(1, 1'b0);
      qnt_scan(1, 1'b1);

      // Concurrent scans with random read gaps
      pack_start = 1'b1; pack_tbl = 0;
      qnt_start = 1'b1; qnt_tbl = 1; qnt_zz = 1'b0;
      step();
      pack_start = 1'b0; qnt_start = 1'b0;
      kp = 0; kq = 0; guard = 0;
      while ((kp < 64 || kq < 64) && guard < 2000) begin
         rp = (kp < 64) && ($urandom_range(0, 1) == 1);
         rq = (kq < 64) && ($urandom_range(0, 1) == 1);
         pack_rd = rp; qnt_rd = rq;
         step();
         chk("cc_pvld", pack_vld, rp);
         chk("cc_qvld", qnt_vld, rq);
         if (rp) begin
            chk("cc_pdata", pack_data, mem_m[0][zzt[kp]]);
            chk("cc_plast", pack_last, (kp == 63));
            kp++;
         end
         if (rq) begin
            chk("cc_qdata", qnt_data, mem_m[1][kq]);
            chk("cc_qlast", qnt_last, (kq == 63));
            kq++;
         end
         chk("cc_busy", busy, ((kp % 64) != 0) || ((kq % 64) != 0));
         guard++;
      end
      if (guard >= 2000) chk("cc_timeout", 0, 1);
      pack_rd = 1'b0; qnt_rd = 1'b0;
      step();

      // Write tbl0[8] while the packer reads zigzag k=2 (raster 8)
      pack_start = 1'b1; pack_tbl = 0; pack_rd = 1'b1;
      step();
      pack_start = 1'b0;
      chk("col_k0", pack_data, 0);
      step();
      chk("col_k1", pack_data, 1);
      wr_en = 1'b1; wr_tbl = 0; wr_idx = 6'd8; wr_data = 8'hAA;
      step();
      wr_en = 1'b0;
      chk("col_old", pack_data, 8);
      mem_m[0][8] = 8'hAA;
      pack_start = 1'b1;
      step();
      pack_start = 1'b0;
      chk("col_re_k0", pack_data, 0);
      step();
      chk("col_re_k1", pack_data, 1);
      step();
      chk("col_new", pack_data, 8'hAA);
      for (int k = 3; k < 37; k++) step();

      // Restart with a same-cycle read at cnt=37, then wrap
      for (int j = 0; j < 65; j++) begin
         pack_start = (j == 0);
         step();
         chk("rs_vld", pack_vld, 1);
         chk("rs_data", pack_data, mem_m[0][zzt[j % 64]]);
         chk("rs_last", pack_last, (j == 63));
      end
      pack_start = 1'b0; pack_rd = 1'b0;
      step();

      // Out-of-range start: flags error and falls back to tbl0
      chk("err_pre", tbl_err, 0);
      qnt_start = 1'b1; qnt_tbl = 2'd3; qnt_zz = 1'b0; qnt_rd = 1'b1;
      pack_start = 1'b1; pack_tbl = 1; pack_rd = 1'b1;
      step();
      qnt_start = 1'b0; pack_start = 1'b0;
      chk("err_start", tbl_err, 1);
      chk("err_rd0", qnt_data, mem_m[0][0]);
      step();
      chk("err_rd1", qnt_data, mem_m[0][1]);
      step();
      chk("err_rd2", qnt_data, mem_m[0][2]);
      chk("err_sticky", tbl_err, 1);

      // Asynchronous reset mid-scan
      rst = 1'b1;
      #1;
      chk("arst_pdata", pack_data, 0);
      chk("arst_qdata", qnt_data, 0);
      chk("arst_pvld", pack_vld, 0);
      chk("arst_qvld", qnt_vld, 0);
      chk("arst_busy", busy, 0);
      chk("arst_err", tbl_err, 0);
      step();
      chk("arst_hold_vld", qnt_vld, 0);
      rst = 1'b0; pack_rd = 1'b0; qnt_rd = 1'b0;
      model_reset();
      step();

      // Out-of-range write: flags error, stores nothing
      wr_en = 1'b1; wr_tbl = 2'd3; wr_idx = 6'd0; wr_data = 8'h55;
      step();
      wr_en = 1'b0;
      chk("err_wr", tbl_err, 1);

      // Packer reads without a start (latched tbl0); quantizer scans tbl1
      qnt_start = 1'b1; qnt_tbl = 1; qnt_zz = 1'b0;
      for (int k = 0; k < 64; k++) begin
         pack_rd = 1'b1; qnt_rd = 1'b1;
         step();
         qnt_start = 1'b0;
         chk("post_pdata", pack_data, 1);
         chk("post_qdata", qnt_data, 1);
         chk("post_plast", pack_last, (k == 63));
      end
      pack_rd = 1'b0; qnt_rd = 1'b0;
      step();
      chk("post_err_sticky", tbl_err, 1);
      chk("post_busy", busy, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
